// File: rtl/flappy_pkg.sv
// flappy_pkg: game state encoding, coordinate widths and the score helper.
package flappy_pkg;

  typedef enum logic [1:0] {
    GS_IDLE = 2'd0,
    GS_RUN  = 2'd1,
    GS_OVER = 2'd2
  } game_state_t;

  localparam int XW  = 10;  // bar column width
  localparam int YW  = 9;   // row width (gap centres, bird row)
  localparam int BXW = 9;   // bird column width
  localparam int CW  = 11;  // signed compare width; holds any sum/difference
  localparam int SW  = 10;  // score width

  // One pass credit: +1 below the bonus threshold, +2 at or above it,
  // clamped to max_val.
  function automatic logic [SW-1:0] score_add(input logic [SW-1:0] score,
                                              input logic [SW-1:0] bonus_at,
                                              input logic [SW-1:0] max_val);
    logic [SW:0] sum;
    sum = {1'b0, score} + ((score >= bonus_at) ? (SW+1)'(2) : (SW+1)'(1));
    return (sum > {1'b0, max_val}) ? max_val : sum[SW-1:0];
  endfunction

endpackage

// File: rtl/game_judge_if.sv
// game_judge_if: bird/bar inputs and game status outputs of the judge.
interface game_judge_if #(
  parameter int N_BARS = 3
);
  import flappy_pkg::*;

  logic                 frame_tick;
  logic                 game_start;
  logic [BXW-1:0]       bird_x;
  logic [YW-1:0]        bird_y;
  logic [4:0]           bird_hw;
  logic [4:0]           bird_hh;
  logic [N_BARS*XW-1:0] bar_x;
  logic [N_BARS*YW-1:0] gap_y;
  logic [N_BARS-1:0]    bar_wrap;
  logic [1:0]           state;
  logic                 lose;
  logic [SW-1:0]        score;
  logic [SW-1:0]        high_score;
  logic                 busy;
  logic                 scan_done;

  // Playfield side: drives bird/bar geometry and control, reads status.
  modport master (
    output frame_tick, game_start, bird_x, bird_y, bird_hw, bird_hh,
           bar_x, gap_y, bar_wrap,
    input  state, lose, score, high_score, busy, scan_done
  );

  // Judge side.
  modport slave (
    input  frame_tick, game_start, bird_x, bird_y, bird_hw, bird_hh,
           bar_x, gap_y, bar_wrap,
    output state, lose, score, high_score, busy, scan_done
  );

endinterface

// File: rtl/bar_check.sv
// bar_check: combinational collision / pass evaluation of the bird against one bar.
module bar_check
  import flappy_pkg::*;
#(
  parameter int BAR_W = 40,
  parameter int GAP_H = 120
) (
  input  logic [BXW-1:0] bird_x,
  input  logic [YW-1:0]  bird_y,
  input  logic [4:0]     bird_hw,
  input  logic [4:0]     bird_hh,
  input  logic [XW-1:0]  bar_x,
  input  logic [YW-1:0]  gap_y,
  output logic           hit,
  output logic           pass
);

  localparam logic signed [CW-1:0] BAR_W_S  = CW'(BAR_W);
  localparam logic signed [CW-1:0] HALF_GAP = CW'(GAP_H / 2);

  // Zero-extend into a signed width so left edges and bird top never wrap.
  logic signed [CW-1:0] bx, by, hw, hh, br, gy;
  logic                 overlap_x, outside_gap;

  assign bx = signed'(CW'(bird_x));
  assign by = signed'(CW'(bird_y));
  assign hw = signed'(CW'(bird_hw));
  assign hh = signed'(CW'(bird_hh));
  assign br = signed'(CW'(bar_x));
  assign gy = signed'(CW'(gap_y));

  assign overlap_x   = (bx + hw >= br - BAR_W_S) && (bx - hw <= br);
  assign outside_gap = (by - hh <= gy - HALF_GAP) || (by + hh >= gy + HALF_GAP);

  assign hit  = overlap_x && outside_gap;
  assign pass = (bx - hw > br) && (by > gy - HALF_GAP) && (by < gy + HALF_GAP);

endmodule

// File: rtl/game_judge.sv
// game_judge: per-frame scan of all bars through one shared evaluator, game FSM and scoring.
module game_judge
  import flappy_pkg::*;
#(
  parameter int N_BARS    = 3,
  parameter int BAR_W     = 40,
  parameter int GAP_H     = 120,
  parameter int FLOOR_Y   = 479,
  parameter int BONUS_AT  = 5,
  parameter int SCORE_MAX = 999
) (
  input logic         clk_25MHz,
  input logic         reset_n,
  game_judge_if.slave bus
);

  localparam logic [1:0] ST_IDLE = GS_IDLE;
  localparam logic [1:0] ST_RUN  = GS_RUN;
  localparam logic [1:0] ST_OVER = GS_OVER;

  localparam int            IW       = (N_BARS > 1) ? $clog2(N_BARS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_BARS - 1);

  logic [1:0]        state_reg, state_next;
  logic              busy_reg, busy_next;
  logic [IW-1:0]     idx_reg, idx_next;
  logic              done_reg, done_next;
  logic [SW-1:0]     score_reg, score_next;
  logic [SW-1:0]     high_reg, high_next;
  logic [N_BARS-1:0] armed_reg, armed_next, clr_mask;
  logic              lose_reg;

  logic [XW-1:0] bar_x_arr [N_BARS];
  logic [YW-1:0] gap_y_arr [N_BARS];
  logic          bar_hit, bar_pass, edge_hit, collide, credit;

  generate
    for (genvar gi = 0; gi < N_BARS; gi++) begin : g_unpack
      assign bar_x_arr[gi] = bus.bar_x[gi*XW +: XW];
      assign gap_y_arr[gi] = bus.gap_y[gi*YW +: YW];
    end
  endgenerate

  // Single evaluator, time-shared across bars by the scan index.
  bar_check #(
    .BAR_W (BAR_W),
    .GAP_H (GAP_H)
  ) u_bar_check (
    .bird_x  (bus.bird_x),
    .bird_y  (bus.bird_y),
    .bird_hw (bus.bird_hw),
    .bird_hh (bus.bird_hh),
    .bar_x   (bar_x_arr[idx_reg]),
    .gap_y   (gap_y_arr[idx_reg]),
    .hit     (bar_hit),
    .pass    (bar_pass)
  );

  assign edge_hit = (CW'(bus.bird_y) + CW'(bus.bird_hh) >= CW'(FLOOR_Y)) ||
                    (CW'(bus.bird_y) < CW'(bus.bird_hh));
  // Floor/ceiling is folded into scan cycle 0 ahead of bar 0.
  assign collide  = ((idx_reg == '0) && edge_hit) || bar_hit;
  assign credit   = bar_pass && armed_reg[idx_reg];

  // Next-state: game FSM, scan sequencing, scoring and credit arming.
  always_comb begin
    state_next = state_reg;
    busy_next  = busy_reg;
    idx_next   = idx_reg;
    done_next  = 1'b0;
    score_next = score_reg;
    high_next  = high_reg;
    clr_mask   = '0;
    case (state_reg)
      ST_IDLE, ST_OVER: begin
        if (bus.game_start) begin
          state_next = ST_RUN;
          score_next = '0;
        end
      end
      ST_RUN: begin
        if (busy_reg) begin
          if (collide) begin
            state_next = ST_OVER;
            busy_next  = 1'b0;
            idx_next   = '0;
            done_next  = 1'b1;
            if (score_reg > high_reg) high_next = score_reg;
          end else begin
            if (credit) begin
              score_next        = score_add(score_reg, SW'(BONUS_AT), SW'(SCORE_MAX));
              clr_mask[idx_reg] = 1'b1;
            end
            if (idx_reg == LAST_IDX) begin
              busy_next = 1'b0;
              idx_next  = '0;
              done_next = 1'b1;
            end else begin
              idx_next = idx_reg + 1'b1;
            end
          end
        end else if (bus.frame_tick) begin
          busy_next = 1'b1;
          idx_next  = '0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // A wrap re-arms even when the same bar is being credited this cycle.
    armed_next = (armed_reg & ~clr_mask) | bus.bar_wrap;
    if ((state_reg != ST_RUN) && bus.game_start) armed_next = '1;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_25MHz) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      busy_reg  <= 1'b0;
      idx_reg   <= '0;
      done_reg  <= 1'b0;
      score_reg <= '0;
      high_reg  <= '0;
      armed_reg <= '1;
      lose_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= busy_next;
      idx_reg   <= idx_next;
      done_reg  <= done_next;
      score_reg <= score_next;
      high_reg  <= high_next;
      armed_reg <= armed_next;
      lose_reg  <= (state_next == ST_OVER);
    end
  end

  assign bus.state      = state_reg;
  assign bus.lose       = lose_reg;
  assign bus.score      = score_reg;
  assign bus.high_score = high_reg;
  assign bus.busy       = busy_reg;
  assign bus.scan_done  = done_reg;

endmodule

// File: doc/game_judge.md
# game_judge

Frame-synchronous collision and scoring engine for the playfield, generalised to `N_BARS` obstacles. It evaluates one bar per cycle after each frame tick and owns the game state machine (idle, run, over). It holds the lose flag, the running score and a persistent high score. It sits between the bar generators and bird on one side and the pixel renderer / score board on the other, all on the 25 MHz pixel clock.

## Interface
- `N_BARS`, 3: number of obstacle channels (1–8).
- `BAR_W`, 40: bar width in pixels; a bar spans columns `bar_x-BAR_W` .. `bar_x`.
- `GAP_H`, 120: vertical gap height; gap spans `gap_y-GAP_H/2` .. `gap_y+GAP_H/2`.
- `FLOOR_Y`, 479: bottom screen row; touching it is a loss.
- `BONUS_AT`, 5: a pass at score ≥ `BONUS_AT` adds 2, otherwise 1.
- `SCORE_MAX`, 999: saturation value of score.
- `clk_25MHz` in 1: pixel clock; the only clock.
- `reset_n` in 1: synchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse per frame; starts a scan.
- `game_start` in 1: level; starts/restarts a game.
- `bird_x` in 9: bird centre column.
- `bird_y` in 9: bird centre row.
- `bird_hw`, `bird_hh` in 5 each: bird half-width and half-height.
- `bar_x` in `N_BARS*10`: packed right-edge columns; bar i is bits `[10i+9:10i]`.
- `gap_y` in `N_BARS*9`: packed gap centres.
- `bar_wrap` in `N_BARS`: per-bar one-cycle pulse when that bar re-enters at the right edge.
- `state` out 2: IDLE=0, RUN=1, OVER=2.
- `lose` out 1: high while in OVER.
- `score` out 10: current score.
- `high_score` out 10: best score since reset.
- `busy` out 1: scan in progress.
- `scan_done` out 1: one-cycle pulse after the last bar is evaluated.

## Operation
- State IDLE: `game_start`=1 → RUN. Clear score and re-arm all credits.
- State RUN: a `frame_tick` while not busy starts a scan with index 0. Bar i is evaluated in the i-th scan cycle.
- State OVER: `game_start`=1 → RUN. Clear score and re-arm credits; `high_score` is kept.
- Arithmetic: all comparisons use 11-bit signed, zero-extended operands, so `bar_x-BAR_W` and `bird_y-bird_hh` never wrap.
- Bar collision condition: `bird_x+hw ≥ bar_x-BAR_W` and `bird_x-hw ≤ bar_x` and (`bird_y-hh ≤ gap_y-GAP_H/2` or `bird_y+hh ≥ gap_y+GAP_H/2`).
- Edge collision: `bird_y+hh ≥ FLOOR_Y` or `bird_y < hh`. It is checked in scan cycle 0 and has priority over bar 0.
- Pass condition: `bird_x-hw > bar_x`, bird_y strictly inside the gap, and `armed[i]`=1. On a pass, clear `armed[i]` and add 1 or 2 to score, saturating at `SCORE_MAX`.
- Priority within a cycle: collision wins over pass.
- On a collision: go to OVER, abort the remaining bars and pulse `scan_done`. Set `high_score` to `max(high_score, score)` in the same cycle.
- `bar_wrap[i]` sets `armed[i]` in any state. If a wrap and a pass credit hit the same bar in the same cycle, `armed[i]` ends at 1.
- `frame_tick` while busy is ignored. Scans run only in RUN.
- `game_start` during a scan in RUN is ignored.

## Timing
- Reset values (applied when `reset_n`=0 at a clock edge):
  - `state`=IDLE, `lose`=0, `score`=0, `high_score`=0.
  - `busy`=0, `scan_done`=0, `armed`=all 1s.
- Reset asserted mid-scan aborts the scan with no score update.
- Scan timing, for a tick sampled at edge k:
  - `busy`=1 from k+1 through k+N_BARS.
  - Bar i result is registered at edge k+1+i.
  - `scan_done` is high during cycle k+N_BARS+1, or the cycle after an aborting collision.
- Latency from tick to `lose`: 1+i+1 cycles for a collision at bar i.
- `lose` is registered and equals (`state`==OVER).
- Bar and bird inputs must be stable from the tick through `scan_done`. They are sampled live each scan cycle, not latched.
- Back-to-back: a `frame_tick` in the same cycle as `scan_done` starts a new scan.

## Structure
- `flappy_pkg` holds:
  - the `game_state_t` enum;
  - coordinate width constants: `XW`=10, `YW`=9, signed compare width 11;
  - the function `score_add(score, bonus_at, max)`.
- Sub-module `bar_check`: combinational single-bar evaluator with outputs `hit` and `pass`.
  - The top instantiates it once and muxes bar i by scan index. The module is not replicated `N_BARS` times.

## Test plan
1. Reset, `game_start`=1, then tick with bird (100,240, hw=hh=10), all bars at x=600, gap 240 → no lose, score 0, `scan_done` pulses 4 cycles after the tick.
2. Bar1 at x=300 with bird at x=320, gap_y=240 → pass credit; score 1. A second tick gives no further credit. `bar_wrap[1]` re-arms, and the next tick gives score 2.
3. Bird y=120 with gap_y=240 overlapping bar2 → lose=1 at tick+4. `high_score` latches the score; a later tick has no effect.
4. Score preset to 5 by passes, then another pass → score 7. Drive passes until the score reaches 999 → score stays 999.
5. Bird y=475, hh=10 → floor collision at scan cycle 0; lose at tick+2; bars 1..N-1 are not evaluated.
6. Pull `reset_n` low mid-scan → all outputs return to reset values on the next edge. Also check `game_start` from OVER → score 0 with `high_score` retained.
